// File: rtl/mem_burst_pkg.sv
// Shared state encoding and field widths for the memory burst controller.
package mem_burst_pkg;

    localparam int ADDR_W = 4;
    localparam int LEN_W  = 4;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry read-data FIFO between the memory return path and the consumer.
module rd_skid_buf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [1:0]    count
);

    logic [DW-1:0] slot_q [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          do_push, do_pop;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slot_q[wr_ptr_q] <= push_data;
    end

    assign head  = slot_q[rd_ptr_q];
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer in front of the single-port memory; define MEM_BURST_CTRL_STATS_EN
// to add saturating write/read beat counters (wr_beats, rd_beats).
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int w = 7,
    parameter int l = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [w:0]        wd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [w:0]        rd_data,
    output logic              mem_enable,
    output logic              mem_wrt_read,
    output logic [ADDR_W-1:0] mem_add,
    output logic [w:0]        mem_write,
    input  logic [w:0]        mem_out,
    output logic              busy,
    output logic              err
`ifdef MEM_BURST_CTRL_STATS_EN
    ,
    output logic [STAT_W-1:0] wr_beats,
    output logic [STAT_W-1:0] rd_beats
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(l);

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              in_flight_q, in_flight_d;
    logic              err_q, err_d;
    logic              cmd_ready_c, wd_ready_c, mem_en_c, mem_wr_c;
    logic              buf_full, buf_empty, rd_pop, room;
    logic [1:0]        buf_count;
    logic [w:0]        buf_head;

    // A read may only be issued if the buffer can still absorb it when it returns.
    assign room = !buf_full && (({1'b0, buf_count} + {2'b00, in_flight_q}) < 3'd2);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        in_flight_d = 1'b0;
        err_d       = 1'b0;
        cmd_ready_c = 1'b0;
        wd_ready_c  = 1'b0;
        mem_en_c    = 1'b0;
        mem_wr_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    remaining_d = cmd_len;
                    if (cmd_addr > LAST_ADDR) err_d = 1'b1;
                    else state_d = cmd_wr ? WRITE : READ;
                end
            end
            WRITE: begin
                wd_ready_c = 1'b1;
                if (wd_valid) begin
                    mem_en_c    = 1'b1;
                    mem_wr_c    = 1'b1;
                    addr_d      = next_addr(addr_q);
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == '0) state_d = IDLE;
                end
            end
            READ: begin
                if (room) begin
                    mem_en_c    = 1'b1;
                    in_flight_d = 1'b1;
                    addr_d      = next_addr(addr_q);
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == '0) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!in_flight_q && buf_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_flight_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= in_flight_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q      <= addr_d;
        remaining_q <= remaining_d;
    end

    rd_skid_buf #(.DW(w + 1)) u_rd_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (in_flight_q),
        .push_data (mem_out),
        .pop       (rd_pop),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // Every output is forced low while reset is held, even mid-burst.
    assign cmd_ready    = cmd_ready_c && !reset;
    assign wd_ready     = wd_ready_c && !reset;
    assign mem_enable   = mem_en_c && !reset;
    assign mem_wrt_read = mem_wr_c && mem_enable;
    assign mem_add      = mem_enable ? addr_q : '0;
    assign mem_write    = mem_wrt_read ? wd_data : '0;
    assign rd_valid     = !buf_empty && !reset;
    assign rd_data      = rd_valid ? buf_head : '0;
    assign rd_pop       = rd_valid && rd_ready;
    assign busy         = (state_q != IDLE) && !reset;
    assign err          = err_q && !reset;

`ifdef MEM_BURST_CTRL_STATS_EN
    logic [STAT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (mem_wrt_read && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 1'b1;
        if (rd_pop && (rd_cnt_q != '1))       rd_cnt_d = rd_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign wr_beats = wr_cnt_q;
    assign rd_beats = rd_cnt_q;
`endif

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Randomized bench for mem_burst_ctrl with a behavioural memory and a reference copy of its contents.
module tb_mem_burst_ctrl;

    localparam int W = 7;
    localparam int L = 10;
    typedef logic [W:0] data_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [3:0]  cmd_addr, cmd_len;
    logic        wd_valid, wd_ready;
    data_t       wd_data;
    logic        rd_valid, rd_ready;
    data_t       rd_data;
    logic        mem_enable, mem_wrt_read;
    logic [3:0]  mem_add;
    data_t       mem_write;
    data_t       mem_out = '0;
    logic        busy, err;

    data_t dev_mem [L+1] = '{default: '0};
    data_t ref_mem [L+1] = '{default: '0};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_burst_ctrl #(.w(W), .l(L)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_wr       (cmd_wr),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .wd_valid     (wd_valid),
        .wd_ready     (wd_ready),
        .wd_data      (wd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .mem_enable   (mem_enable),
        .mem_wrt_read (mem_wrt_read),
        .mem_add      (mem_add),
        .mem_write    (mem_write),
        .mem_out      (mem_out),
        .busy         (busy),
        .err          (err)
    );

    // Memory device: write at the edge, read data appears on mem_out after the edge.
    always @(posedge clk) begin
        if (mem_enable && int'(mem_add) <= L) begin
            if (mem_wrt_read) dev_mem[mem_add] <= mem_write;
            else              mem_out <= dev_mem[mem_add];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int nxt(input int a);
        return (a + 1) % (L + 1);
    endfunction

    task automatic do_write(input int a, input int len, input bit fixed, input bit gaps);
        int    ea = a;
        int    beats = 0;
        int    budget = 0;
        data_t d;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'(a); cmd_len = 4'(len);
        #1;
        check_eq("wr_cmd_ready", cmd_ready, 1);
        check_eq("wr_idle_mem_en", mem_enable, 0);
        while (beats <= len && budget < 100) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            wd_valid  = (gaps && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            d         = fixed ? data_t'(8'h11 * (beats + 1)) : data_t'($urandom);
            wd_data   = d;
            #1;
            check_eq("wr_busy", busy, 1);
            check_eq("wr_wd_ready", wd_ready, 1);
            check_eq("wr_mem_en", mem_enable, wd_valid);
            if (wd_valid) begin
                check_eq("wr_dir", mem_wrt_read, 1);
                check_eq("wr_addr", mem_add, ea);
                check_eq("wr_data", mem_write, d);
                ref_mem[ea] = d;
                ea = nxt(ea);
                beats++;
            end else begin
                check_eq("wr_gap_data", mem_write, 0);
            end
            budget++;
        end
        if (budget >= 100) check_eq("wr_timeout", 1, 0);
        @(negedge clk);
        wd_valid = 1'b0;
        #1;
        check_eq("wr_done_busy", busy, 0);
        check_eq("wr_done_cmd_ready", cmd_ready, 1);
        check_eq("wr_done_mem_en", mem_enable, 0);
    endtask

    task automatic do_read(input int a, input int len, input int stall, input bit rnd);
        data_t q[$];
        int    ea = a;
        int    ia = a;
        int    cyc = 0;
        int    issued = 0;
        int    stall_iss = 0;
        int    first = -1;
        bit    done = 1'b0;
        for (int i = 0; i <= len; i++) begin
            q.push_back(ref_mem[ea]);
            ea = nxt(ea);
        end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'(a); cmd_len = 4'(len); rd_ready = 1'b0;
        #1;
        check_eq("rd_cmd_ready", cmd_ready, 1);
        while (!done && cyc < 200) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (cyc < stall) rd_ready = 1'b0;
            else             rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            cyc++;
            if (mem_enable) begin
                check_eq("rd_dir", mem_wrt_read, 0);
                check_eq("rd_addr", mem_add, ia);
                check_eq("rd_mem_write", mem_write, 0);
                ia = nxt(ia);
                issued++;
                if (cyc <= stall) stall_iss++;
            end
            if (rd_valid && first < 0) first = cyc;
            if (rd_valid && rd_ready) begin
                if (q.size() == 0) check_eq("rd_extra_word", 1, 0);
                else               check_eq("rd_data", rd_data, q.pop_front());
            end
            if (q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) check_eq("rd_timeout", 1, 0);
        check_eq("rd_issued", issued, len + 1);
        if (stall >= 5) check_eq("rd_stall_issues", stall_iss, 2);
        if (stall == 0) check_eq("rd_first_latency", first, 3);
        check_eq("rd_done_valid", rd_valid, 0);
        check_eq("rd_done_cmd_ready", cmd_ready, 1);
        rd_ready = 1'b0;
    endtask

    task automatic do_err(input int a);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'($urandom); cmd_addr = 4'(a); cmd_len = 4'($urandom);
        #1;
        check_eq("err_pre", err, 0);
        check_eq("err_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        check_eq("err_pulse", err, 1);
        check_eq("err_still_ready", cmd_ready, 1);
        check_eq("err_busy", busy, 0);
        check_eq("err_mem_en", mem_enable, 0);
        @(negedge clk);
        #1;
        check_eq("err_one_cycle", err, 0);
        check_eq("err_mem_en2", mem_enable, 0);
    endtask

    task automatic do_reset_mid();
        int cyc = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd0; cmd_len = 4'd7; rd_ready = 1'b0;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            cyc++;
        end while (!rd_valid && cyc < 20);
        check_eq("rst_word_buffered", rd_valid, 1);
        check_eq("rst_busy_before", busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mem_en", mem_enable, 0);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_rd_data", rd_data, 0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("rst_no_access", mem_enable, 0);
            check_eq("rst_no_valid", rd_valid, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_cmd_ready", cmd_ready, 0);
        check_eq("reset_wd_ready", wd_ready, 0);
        check_eq("reset_rd_valid", rd_valid, 0);
        check_eq("reset_rd_data", rd_data, 0);
        check_eq("reset_mem_en", mem_enable, 0);
        check_eq("reset_mem_add", mem_add, 0);
        check_eq("reset_mem_write", mem_write, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("post_reset_cmd_ready", cmd_ready, 1);

        do_write(2, 3, 1'b1, 1'b0);
        do_read(2, 3, 0, 1'b0);
        do_read(2, 3, 5, 1'b0);
        do_write(9, 3, 1'b1, 1'b0);
        do_read(9, 3, 0, 1'b0);
        do_err(12);
        do_reset_mid();
        do_read(2, 3, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            a = $urandom_range(0, 15);
            if (a > L)                   do_err(a);
            else if ($urandom_range(0, 1) == 1) do_write(a, $urandom_range(0, 15), 1'b0, 1'b1);
            else                         do_read(a, $urandom_range(0, 15), $urandom_range(0, 6), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
- Upstream sequencer for the `memory` block.
- Accepts burst commands (start address, length, direction) over a valid/ready handshake.
- Generates per-cycle `memory` accesses (`enable`, `wrt_read`, `add`, `write`).
- Streams write data in and read data out, both with valid/ready flow control. Read data is absorbed into a 2-entry buffer so downstream backpressure never loses a word.

Parameters:
- w, 7, data MSB index; data width is w+1.
- l, 10, highest valid memory address; the memory holds l+1 words; must be ≤ 15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  burst command offered.
- cmd_ready  out  1  controller can accept a command.
- cmd_wr  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  4  start address.
- cmd_len  in  4  beats minus one (1..16 beats).
- wd_valid  in  1  write data offered.
- wd_ready  out  1  write data accepted this cycle.
- wd_data  in  w+1  write data.
- rd_valid  out  1  read data available.
- rd_ready  in  1  consumer takes read data.
- rd_data  out  w+1  read data.
- mem_enable  out  1  drives memory `enable`.
- mem_wrt_read  out  1  drives memory `wrt_read`.
- mem_add  out  4  drives memory `add`.
- mem_write  out  w+1  drives memory `write`.
- mem_out  in  w+1  memory `out`.
- busy  out  1  state ≠ IDLE.
- err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset (synchronous, highest priority; may be asserted mid-burst):
  - State → IDLE, read buffer emptied, in-flight flag cleared.
  - All outputs 0: cmd_ready, wd_ready, rd_valid, rd_data, mem_*, busy, err.
  - A burst interrupted by reset is abandoned; no further memory accesses.
- Memory timing: a read issued at edge t (enable=1, wrt_read=0) returns its data on mem_out after edge t+1. Write latency is irrelevant to this block.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr, and load remaining = cmd_len.
  - If cmd_addr > l: err=1 for the next cycle, stay IDLE, no memory access.
  - Otherwise go to WRITE (cmd_wr=1) or READ (cmd_wr=0).
- WRITE:
  - wd_ready=1.
  - Each cycle with wd_valid=1: mem_enable=1, mem_wrt_read=1, mem_add=addr, mem_write=wd_data.
  - After each beat, advance addr and decrement remaining. After the last beat (remaining was 0) go to IDLE.
  - Cycles with wd_valid=0: mem_enable=0.
- READ:
  - Issue one read per cycle while (buffer occupancy + in-flight) < 2.
  - The in-flight flag is set on issue; the next cycle's mem_out is captured into the buffer.
  - After the last issue go to DRAIN.
- DRAIN:
  - No memory accesses.
  - Return to IDLE when in-flight = 0 and the buffer is empty.
  - cmd_ready stays 0 until then.
- Address wrap: next addr = (addr == l) ? 0 : addr+1, so bursts wrap inside 0..l.
- Read buffer (2-entry FIFO):
  - rd_valid = not empty; rd_data = head.
  - Pop on rd_valid && rd_ready. Push and pop in the same cycle is allowed; occupancy is unchanged.
  - Never overflows, by the issue rule.
  - Read data is returned in issue order.
- mem_write = 0 whenever mem_enable=0 or mem_wrt_read=0.
- busy = (state ≠ IDLE).

Optional Feature:
- Macro: MEM_BURST_CTRL_STATS_EN.
- Defined:
  - Adds output ports wr_beats (16 bits) and rd_beats (16 bits).
  - They count completed write beats and read beats delivered (rd_valid && rd_ready).
  - Counters saturate at 0xFFFF and are cleared by reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_burst_pkg holds:
  - state enum (IDLE, WRITE, READ, DRAIN);
  - ADDR_W = 4;
  - LEN_W = 4;
  - STAT_W = 16.
- One sub-module: rd_skid_buf, the 2-entry read FIFO with push/pop, full/empty and a count output.
- The controller FSM stays in mem_burst_ctrl.

Test Plan:
- Write burst: cmd (wr=1, addr=2, len=3), wd_data 0x11,0x22,0x33,0x44 with wd_valid held 1 → writes to mem[2..5] on 4 consecutive cycles; state returns to IDLE; busy 1→0.
- Read burst: cmd (wr=0, addr=2, len=3), rd_ready=1 → rd_data 0x11,0x22,0x33,0x44 in order; first rd_valid 2 cycles after cmd acceptance.
- Backpressure: the same read with rd_ready=0 for 5 cycles → exactly 2 reads issued, then issue stalls. Releasing rd_ready yields all 4 words in order with no loss or duplication.
- Wrap: write burst addr=9, len=3 (l=10) → accesses at 9, 10, 0, 1; read back confirms.
- Error: cmd addr=12 → err pulses 1 cycle, mem_enable stays 0, cmd_ready remains 1.
- Reset mid-burst: assert reset during a read with 1 word buffered → next cycle rd_valid=0, busy=0, mem_enable=0. A new command is accepted normally afterwards.
